// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: widths, channel limit, default half-periods.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned N_CH_MAX  = 8;

   // Half-period minus one for the default channels (ch0, ch1, ch2).
   localparam logic [15:0] HALF_SERIAL = 16'd255;
   localparam logic [15:0] HALF_DIGIT  = 16'd4095;
   localparam logic [15:0] HALF_POLL   = 16'd1023;

   // Width of a channel select; never less than one bit.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, shadowed half-period and toggling output.
module clk_div_ch #(
   parameter int unsigned          CNT_W     = 16,
   parameter logic [CNT_W-1:0]     HALF_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             div_clk_o,
   output logic             div_tick_o,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;

   // Next-state: disable beats sync beats terminal count; config write applied last.
   always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;

      if (!en_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
         if (pend_q) begin
            active_d = pending_q;
            pend_d   = 1'b0;
         end
      end else if (sync_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (cnt_q >= active_q) begin
         // >= rather than == so a shrunken half-period can never strand the counter.
         cnt_d  = '0;
         clk_d  = ~clk_q;
         tick_d = 1'b1;
         // Load only on the falling toggle so each period is whole.
         if (clk_q && pend_q) begin
            active_d = pending_q;
            pend_d   = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A same-cycle write stays pending; the old pending value was the one loaded above.
      if (we_i) begin
         pending_d = half_i;
         pend_d    = 1'b1;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         active_q  <= HALF_INIT;
         pending_q <= HALF_INIT;
         pend_q    <= 1'b0;
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
      end
   end

   assign div_clk_o  = clk_q;
   assign div_tick_o = tick_q;
   assign busy_o     = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers with glitch-free runtime half-period updates.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned              N_CH      = 3,
   parameter int unsigned              CNT_W     = CNT_W_DEF,
   parameter logic [N_CH*CNT_W-1:0]    HALF_INIT = {HALF_POLL, HALF_DIGIT, HALF_SERIAL}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CH-1:0]           ch_en,
   input  logic                      sync,
   input  logic                      cfg_we,
   input  logic [ch_w(N_CH)-1:0]     cfg_ch,
   input  logic [CNT_W-1:0]          cfg_half,
   output logic [N_CH-1:0]           div_clk,
   output logic [N_CH-1:0]           div_tick,
   output logic [N_CH-1:0]           cfg_busy
);

   logic [N_CH-1:0] we_vec;

   // Channel-select decode; out-of-range selects match no channel and are dropped.
   always_comb begin
      we_vec = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (cfg_we && (int'(cfg_ch) == i)) begin
            we_vec[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_ch #(
         .CNT_W     (CNT_W),
         .HALF_INIT (HALF_INIT[g*CNT_W +: CNT_W])
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .en_i       (ch_en[g]),
         .sync_i     (sync),
         .we_i       (we_vec[g]),
         .half_i     (cfg_half),
         .div_clk_o  (div_clk[g]),
         .div_tick_o (div_tick[g]),
         .busy_o     (cfg_busy[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench: event-scheduled reference model of the divider bank.
module tb_clk_div_bank;

   localparam int NCH = 3;
   localparam int CW  = 16;

   logic           clk;
   logic           rst_n;
   logic [NCH-1:0] ch_en;
   logic           sync;
   logic           cfg_we;
   logic [1:0]     cfg_ch;
   logic [CW-1:0]  cfg_half;
   logic [NCH-1:0] div_clk;
   logic [NCH-1:0] div_tick;
   logic [NCH-1:0] cfg_busy;

   int errors;
   int checks;

   clk_div_bank dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_en    (ch_en),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_half (cfg_half),
      .div_clk  (div_clk),
      .div_tick (div_tick),
      .cfg_busy (cfg_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each channel holds its output level and the absolute edge number of its next toggle.
   int unsigned cyc;
   int unsigned init_half [NCH] = '{255, 4095, 1023};
   int unsigned m_half [NCH];
   int unsigned m_pend [NCH];
   int unsigned m_next [NCH];
   bit          m_pv   [NCH];
   bit          m_lvl  [NCH];
   bit          m_tick [NCH];

   task automatic model_edge();
      cyc++;
      for (int i = 0; i < NCH; i++) begin
         m_tick[i] = 1'b0;
         if (!rst_n) begin
            m_half[i] = init_half[i];
            m_pend[i] = init_half[i];
            m_pv[i]   = 1'b0;
            m_lvl[i]  = 1'b0;
            m_next[i] = cyc + m_half[i] + 1;
         end else begin
            if (!ch_en[i]) begin
               m_lvl[i] = 1'b0;
               if (m_pv[i]) begin
                  m_half[i] = m_pend[i];
                  m_pv[i]   = 1'b0;
               end
               m_next[i] = cyc + m_half[i] + 1;
            end else if (sync) begin
               m_lvl[i]  = 1'b0;
               m_next[i] = cyc + m_half[i] + 1;
            end else if (cyc == m_next[i]) begin
               m_tick[i] = 1'b1;
               if (m_lvl[i] && m_pv[i]) begin
                  m_half[i] = m_pend[i];
                  m_pv[i]   = 1'b0;
               end
               m_lvl[i]  = ~m_lvl[i];
               m_next[i] = cyc + m_half[i] + 1;
            end
            if (cfg_we && int'(cfg_ch) == i) begin
               m_pend[i] = int'(cfg_half);
               m_pv[i]   = 1'b1;
            end
         end
      end
   endtask

   // One clock edge: advance model, then compare all outputs 1 time unit later.
   task automatic step();
      logic [NCH-1:0] e_clk, e_tick, e_busy;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < NCH; i++) begin
         e_clk[i]  = m_lvl[i];
         e_tick[i] = m_tick[i];
         e_busy[i] = m_pv[i];
      end
      checks++;
      assert (div_clk === e_clk) else begin
         errors++;
         $error("FAIL div_clk cyc=%0d got=%b exp=%b", cyc, div_clk, e_clk);
      end
      checks++;
      assert (div_tick === e_tick) else begin
         errors++;
         $error("FAIL div_tick cyc=%0d got=%b exp=%b", cyc, div_tick, e_tick);
      end
      checks++;
      assert (cfg_busy === e_busy) else begin
         errors++;
         $error("FAIL cfg_busy cyc=%0d got=%b exp=%b", cyc, cfg_busy, e_busy);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write_cfg(input int ch, input int half);
      cfg_we   = 1'b1;
      cfg_ch   = 2'(ch);
      cfg_half = CW'(half);
      step();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int n;
      errors   = 0;
      checks   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      ch_en    = '1;
      sync     = 1'b0;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_half = '0;
      for (int i = 0; i < NCH; i++) begin
         m_half[i] = init_half[i];
         m_pend[i] = init_half[i];
         m_pv[i]   = 1'b0;
         m_lvl[i]  = 1'b0;
         m_tick[i] = 1'b0;
         m_next[i] = 0;
      end
      #2;
      checks++;
      assert ({div_clk, div_tick, cfg_busy} === 9'b0) else begin
         errors++;
         $error("FAIL reset_outs got=%b exp=0", {div_clk, div_tick, cfg_busy});
      end
      run(3);
      rst_n = 1'b1;

      // Defaults, all enabled.
      run(20000);

      // ch0: shorten to half=3 while its output is high.
      n = 0;
      while (!m_lvl[0] && n < 2000) begin
         step();
         n++;
      end
      checks++;
      assert (n < 2000) else begin
         errors++;
         $error("FAIL wait_ch0_high got=%0d exp<2000", n);
      end
      run(50);
      write_cfg(0, 3);
      run(600);

      // ch1: two writes before the boundary; last one wins.
      write_cfg(1, 9);
      run(5);
      write_cfg(1, 5);
      run(9000);

      // ch2: pending 0 then disable mid-period, then re-enable.
      write_cfg(2, 0);
      ch_en[2] = 1'b0;
      run(4);
      ch_en[2] = 1'b1;
      run(20);

      // Bring ch0 and ch2 to half=7, then sync them.
      write_cfg(0, 7);
      write_cfg(2, 7);
      run(40);
      ch_en[2] = 1'b0;
      run(3);
      ch_en[2] = 1'b1;
      run(11);
      sync = 1'b1;
      step();
      sync = 1'b0;
      run(60);

      // Async reset mid-period with writes pending.
      write_cfg(0, 2);
      write_cfg(1, 3);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      assert ({div_clk, div_tick, cfg_busy} === 9'b0) else begin
         errors++;
         $error("FAIL async_rst got=%b exp=0", {div_clk, div_tick, cfg_busy});
      end
      run(3);
      rst_n = 1'b1;
      run(600);

      // Random traffic with small half-periods and an out-of-range channel select.
      for (int i = 0; i < NCH; i++) write_cfg(i, 4);
      for (int k = 0; k < 5000; k++) begin
         if ($urandom_range(0, 199) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
         sync     = ($urandom_range(0, 299) == 0);
         cfg_we   = ($urandom_range(0, 19) == 0);
         cfg_ch   = 2'($urandom_range(0, 3));
         cfg_half = CW'($urandom_range(0, 15));
         step();
      end
      sync   = 1'b0;
      cfg_we = 1'b0;
      ch_en  = '1;
      run(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock dividers that generates the design's slow clocks from the single system clock. Examples are the serial shift clock, the display digit clock and the keyboard polling clock. Each channel has a runtime-programmable half-period, an enable, and a one-cycle toggle strobe. Divisor changes are glitch-free: they are applied only at a period boundary. A global sync input phase-aligns all channels. The block sits at the top level and feeds the serial display driver and the keyboard scanner.

## Interface
- N_CH, 3: number of divider channels (1..8).
- CNT_W, 16: counter and half-period width.
- HALF_INIT, {16'd1023, 16'd4095, 16'd255}: packed N_CH×CNT_W reset half-period values. Channel 0 occupies the LSBs. The value is the half-period minus one.
- clk  in  1: system clock; all logic is on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- ch_en  in  N_CH: per-channel run enable.
- sync  in  1: one-cycle pulse that restarts every channel in phase.
- cfg_we  in  1: half-period write strobe.
- cfg_ch  in  $clog2(N_CH) (minimum 1): target channel for the write.
- cfg_half  in  CNT_W: new half-period minus one.
- div_clk  out  N_CH: divided square-wave outputs.
- div_tick  out  N_CH: one-cycle pulse in the same cycle that div_clk toggles.
- cfg_busy  out  N_CH: a pending half-period value is waiting for its boundary.

## Operation
- Per-channel state:
  - cnt[CNT_W]
  - active_half
  - pending_half
  - pend_valid
  - div_clk
- Reset values (asynchronous):
  - cnt = 0
  - active_half and pending_half = HALF_INIT slice
  - pend_valid = 0
  - div_clk = 0, div_tick = 0, cfg_busy = 0
- Running (ch_en=1, sync=0):
  - If cnt >= active_half, this is the terminal cycle: cnt←0, div_clk toggles, div_tick=1.
  - Otherwise cnt←cnt+1 and div_tick=0.
  - The compare is >= so the channel recovers if cnt ever exceeds active_half.
- Boundary load:
  - On a terminal cycle where the output toggles 1→0, if pend_valid then active_half←pending_half and pend_valid←0.
  - This makes changes take effect only at a full-period boundary, so there are no runt pulses.
- Config write (cfg_we=1):
  - pending_half[cfg_ch]←cfg_half and pend_valid←1.
  - A write in the same cycle as a boundary load keeps the new value pending; the old pending value is the one loaded.
  - A later write before the boundary overwrites pending (last write wins).
  - cfg_ch ≥ N_CH is ignored.
- Disabled (ch_en=0):
  - cnt held at 0 and div_clk forced to 0; div_tick=0.
  - A pending value is applied immediately (next edge) and pend_valid cleared.
- Sync: every channel gets cnt←0 and div_clk←0 with no tick. Pending values on enabled channels remain pending. sync has priority over the terminal cycle.
- cfg_busy = pend_valid (registered).
- Arithmetic:
  - Half-period is active_half+1 cycles; full period is 2·(active_half+1) cycles.
  - active_half=0 gives clk/2.
  - There is no wrap-around: cnt never exceeds the maximum CNT_W value, because terminal detection restarts it.

## Timing
- Enable rising at edge E: the first div_clk rise occurs at edge E+active_half+1, with div_tick high in the same cycle.
- After rst_n deassertion with ch_en=1, the first rise occurs on edge active_half+1 (edge 256 for half=255).
- A write takes effect at the first falling-edge boundary after the write edge.
- Worst-case latency of a write is one full old period plus one cycle.
- sync restarts the counters on the next edge. After sync, all channels with equal half-periods toggle in the same cycle.
- Every output is a register; there are no combinational paths from inputs to outputs.

## Structure
- Package clk_div_pkg holds:
  - CNT_W default
  - maximum N_CH
  - the HALF_INIT defaults for the serial, digit and poll channels as named constants
- Sub-module clk_div_ch implements one channel (counter, shadow register, toggle). It is generated N_CH times.
- The top level handles cfg_ch decode, sync fan-out and the packed HALF_INIT slicing.

## Test plan
- Reset with defaults, all enabled for 20000 cycles:
  - ch0 period 512 cycles, first rise at cycle 256
  - ch1 period 8192
  - ch2 period 2048
  - exactly one div_tick per toggle
- ch0 running at half=255; write cfg_half=3 to ch0 mid-high phase:
  - cfg_busy=1
  - the current period completes at 256/256
  - then the period becomes 8
  - cfg_busy drops at the load edge
  - no pulse shorter than 4 cycles
- Two writes (9, then 5) to ch1 before its boundary → only 5 is applied; 9 is never observed.
- Deassert ch_en[2] mid-period with a pending write of 0:
  - div_clk[2]=0 on the next edge; pending applied and cfg_busy[2]=0
  - re-enable → clk/2 output, first rise 1 cycle later
- sync pulse while ch0 and ch2 are both at half=7 and out of phase → both restart and thereafter toggle in identical cycles; no tick in the sync cycle.
- Assert rst_n low asynchronously mid-period with writes pending → all outputs 0 immediately and half-periods back to HALF_INIT; normal operation after release.
